// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scanner: segment bit order,
// active-low hex glyphs and the nibble-to-glyph lookup.
package seven_segment_pkg;

    // Bit position of each segment inside the 7-bit seg bus (a is the MSB).
    typedef enum logic [2:0] {
        SEG_G = 3'd0,
        SEG_F = 3'd1,
        SEG_E = 3'd2,
        SEG_D = 3'd3,
        SEG_C = 3'd4,
        SEG_B = 3'd5,
        SEG_A = 3'd6
    } seg_pos_e;

    // Active-low glyphs: a 0 bit lights the segment.
    localparam logic [6:0] GLYPH_0   = 7'h01;
    localparam logic [6:0] GLYPH_1   = 7'h4F;
    localparam logic [6:0] GLYPH_2   = 7'h12;
    localparam logic [6:0] GLYPH_3   = 7'h06;
    localparam logic [6:0] GLYPH_4   = 7'h4C;
    localparam logic [6:0] GLYPH_5   = 7'h24;
    localparam logic [6:0] GLYPH_6   = 7'h20;
    localparam logic [6:0] GLYPH_7   = 7'h0F;
    localparam logic [6:0] GLYPH_8   = 7'h00;
    localparam logic [6:0] GLYPH_9   = 7'h04;
    localparam logic [6:0] GLYPH_A   = 7'h08;
    localparam logic [6:0] GLYPH_B   = 7'h60;
    localparam logic [6:0] GLYPH_C   = 7'h31;
    localparam logic [6:0] GLYPH_D   = 7'h42;
    localparam logic [6:0] GLYPH_E   = 7'h30;
    localparam logic [6:0] GLYPH_F   = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Map a hex nibble onto its active-low glyph.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return GLYPH_0;
            4'h1:    return GLYPH_1;
            4'h2:    return GLYPH_2;
            4'h3:    return GLYPH_3;
            4'h4:    return GLYPH_4;
            4'h5:    return GLYPH_5;
            4'h6:    return GLYPH_6;
            4'h7:    return GLYPH_7;
            4'h8:    return GLYPH_8;
            4'h9:    return GLYPH_9;
            4'hA:    return GLYPH_A;
            4'hB:    return GLYPH_B;
            4'hC:    return GLYPH_C;
            4'hD:    return GLYPH_D;
            4'hE:    return GLYPH_E;
            4'hF:    return GLYPH_F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Purely combinational nibble-to-glyph decoder for the scanner's muxed digit.
module seg_hex_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Look up the active-low glyph for the selected nibble.
    always_comb begin
        glyph = hex_glyph(nibble);
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered
// hex value. Committed data only changes when the digit index wraps to 0, so a
// frame never mixes old and new digits.
// Optional build macro: SEVEN_SEGMENT_LZB_EN enables leading-zero blanking.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic                pend_valid_q, pend_valid_d;
    logic                wrap_q, wrap_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                terminal_s;
    logic                wrap_s;
    logic [3:0]          nibble_s;
    logic [6:0]          glyph_s;
    logic                lzb_s;

    // Prescaler and digit index: advance the index on each terminal count.
    always_comb begin
        terminal_s = (presc_q == PRE_LAST);
        wrap_s     = terminal_s && (idx_q == IDX_LAST);
        presc_d    = presc_q;
        idx_d      = idx_q;
        if (terminal_s) begin
            presc_d = '0;
            if (wrap_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    // Double buffer: loads land in pending; the frame wrap commits to display.
    // A load coincident with the wrap bypasses pending and commits directly.
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        wrap_d       = wrap_s;
        if (wrap_s) begin
            if (load) begin
                disp_d       = value;
                pend_d       = value;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                disp_d       = pend_q;
                pend_valid_d = 1'b0;
            end else begin
                disp_d = disp_q;
            end
        end else if (load) begin
            pend_d       = value;
            pend_valid_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // Select the nibble of the committed value for the active digit.
    always_comb begin
        nibble_s = disp_q[4*int'(idx_q) +: 4];
    end

    seg_hex_decode u_decode (
        .nibble (nibble_s),
        .glyph  (glyph_s)
    );

`ifdef SEVEN_SEGMENT_LZB_EN
    logic [DIGITS-1:0] lz_mask_s;
    logic              lz_run_s;

    // Leading-zero mask: bit k set when nibbles k..DIGITS-1 are all zero.
    always_comb begin
        lz_run_s  = 1'b1;
        lz_mask_s = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_run_s     = lz_run_s & (disp_q[4*k +: 4] == 4'h0);
            lz_mask_s[k] = lz_run_s;
        end
        lzb_s = (idx_q != '0) && lz_mask_s[idx_q];
    end
`else
    assign lzb_s = 1'b0;
`endif

    // Next output values; blank only masks the pins, scanning keeps running.
    always_comb begin
        seg_d        = SEG_BLANK;
        an_d         = {DIGITS{1'b1}};
        frame_done_d = wrap_q;
        if (blank) begin
            seg_d = SEG_BLANK;
            an_d  = {DIGITS{1'b1}};
        end else begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (lzb_s) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = glyph_s;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            disp_q       <= '0;
            pend_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= {DIGITS{1'b1}};
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            pend_valid_q <= pend_valid_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (DIGITS=4, REFRESH_DIV=4).
// Expected per-cycle outputs are queued frame by frame and popped as the
// DUT produces them.
module tb_seven_segment_scanner;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int FRAME       = DIGITS * REFRESH_DIV;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        load  = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seven_segment_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h01;  4'h1: return 7'h4F;
            4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;
            4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;
            4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;
            4'hE: return 7'h30;  4'hF: return 7'h38;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] disp, input int k);
        logic [3:0] nib;
        nib = disp[4*k +: 4];
`ifdef SEVEN_SEGMENT_LZB_EN
        if (k > 0 && (disp >> (4*k)) == 16'h0000) return 7'h7F;
`endif
        return glyph(nib);
    endfunction

    // Queue one frame of expected outputs; cycles blank_lo..blank_hi are blanked.
    task automatic push_frame(input logic [15:0] disp, input logic fd_first,
                              input int blank_lo, input int blank_hi);
        for (int i = 0; i < FRAME; i++) begin
            exp_t e;
            int   k;
            k    = i / REFRESH_DIV;
            e.fd = (i == 0) ? fd_first : 1'b0;
            if (i >= blank_lo && i <= blank_hi) begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end else begin
                e.an  = ~(4'b0001 << k);
                e.seg = exp_seg(disp, k);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance n clock edges, comparing each cycle against the queue head.
    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL queue_underrun: no expected entry at time %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("an", {28'h0, an}, {28'h0, e.an});
                check("seg", {25'h0, seg}, {25'h0, e.seg});
                check("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, {28'h0, an}, 32'h0000000F);
        check({tag, "_seg"}, {25'h0, seg}, 32'h0000007F);
        check({tag, "_fd"}, {31'h0, frame_done}, 32'h00000000);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Frame 0: all zeros, no frame_done at release; load 9A3F mid-frame.
        push_frame(16'h0000, 1'b0, FRAME, -1);
        step(3);
        value = 16'h9A3F; load = 1'b1;
        step(1);
        load = 1'b0;
        step(12);

        // Frame 1: decode of 9A3F; loads 1111 then 2222 must not tear.
        push_frame(16'h9A3F, 1'b1, FRAME, -1);
        step(5);
        value = 16'h1111; load = 1'b1;
        step(1);
        load = 1'b0;
        step(5);
        value = 16'h2222; load = 1'b1;
        step(1);
        load = 1'b0;
        step(4);

        // Frame 2: last write wins; load 0007 on the wrap edge.
        push_frame(16'h2222, 1'b1, FRAME, -1);
        step(15);
        value = 16'h0007; load = 1'b1;
        step(1);
        load = 1'b0;

        // Frame 3: direct commit of 0007.
        push_frame(16'h0007, 1'b1, FRAME, -1);
        step(16);

        // Frame 4/5: blank raised mid-digit 0, held across the wrap.
        push_frame(16'h0007, 1'b1, 2, FRAME - 1);
        step(2);
        blank = 1'b1;
        step(14);
        push_frame(16'h0007, 1'b1, 0, 1);
        step(2);
        blank = 1'b0;
        step(3);
        value = 16'h1234; load = 1'b1;
        step(1);
        load = 1'b0;
        step(4);

        // Asynchronous reset mid-frame: outputs return at once, pending lost.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        @(negedge clk);
        rst = 1'b0;
        push_frame(16'h0000, 1'b0, FRAME, -1);
        push_frame(16'h0000, 1'b1, FRAME, -1);
        step(2 * FRAME);

        // Leading zeros: load 0050.
        push_frame(16'h0000, 1'b1, FRAME, -1);
        step(4);
        value = 16'h0050; load = 1'b1;
        step(1);
        load = 1'b0;
        step(11);
        push_frame(16'h0050, 1'b1, FRAME, -1);
        step(16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
